// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - 5-stage pipeline sequencer: per-stage hold/flush, multi-cycle EX countdown, redirect flush window (optional perf counters: PIPE_CTRL_PERF_EN)
module pipe_ctrl #(
  parameter int FLUSH_CYCLES = 1,
  parameter int MC_CNT_W     = 4,
  parameter int PERF_W       = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stallreq_id,
  input  logic                mc_start,
  input  logic [MC_CNT_W-1:0] mc_cycles,
  input  logic                br_req,
  input  logic [31:0]         br_addr,
  output logic [5:0]          stall,
  output logic                flush,
  output logic [31:0]         flush_pc,
  output logic                mc_busy
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [PERF_W-1:0]   stall_cnt,
  output logic [PERF_W-1:0]   flush_cnt
`endif
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MC_BUSY = 2'd1,
    FLUSH   = 2'd2
  } state_t;

  localparam logic [5:0] STALL_MC = 6'b001111;  // hold pc..ex_mem while EX is occupied
  localparam logic [5:0] STALL_ID = 6'b000111;  // hold pc..id_ex, bubble into ex_mem
  localparam logic [2:0] FC_INIT  = 3'(FLUSH_CYCLES - 1);
  localparam logic [MC_CNT_W-1:0] MC_ONE = MC_CNT_W'(1);

  state_t                state, state_nx;
  logic [2:0]            fcnt, fcnt_nx;
  logic [MC_CNT_W-1:0]   mcnt, mcnt_nx;
  logic [31:0]           addr_q;
  logic                  br_acc;
  logic [5:0]            stall_c;
  logic                  flush_c;
  logic [31:0]           flush_pc_c;
  logic                  mc_busy_c;

  // State, countdowns and latched redirect target
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= RUN;
      fcnt   <= '0;
      mcnt   <= '0;
      addr_q <= '0;
    end else begin
      state <= state_nx;
      fcnt  <= fcnt_nx;
      mcnt  <= mcnt_nx;
      if (br_acc) addr_q <= br_addr;
    end
  end

  // Next-state and raw (pre-reset-gating) outputs; priority br_req > mc_start > stallreq_id
  always_comb begin
    state_nx   = state;
    fcnt_nx    = fcnt;
    mcnt_nx    = mcnt;
    br_acc     = 1'b0;
    stall_c    = 6'b0;
    flush_c    = 1'b0;
    flush_pc_c = 32'b0;
    mc_busy_c  = 1'b0;
    unique case (state)
      RUN: begin
        if (br_req) begin
          br_acc     = 1'b1;
          flush_c    = 1'b1;
          flush_pc_c = br_addr;
          if (FLUSH_CYCLES > 1) begin
            state_nx = FLUSH;
            fcnt_nx  = FC_INIT;
          end
        end else if (mc_start && (mc_cycles != '0)) begin
          stall_c   = STALL_MC;
          mc_busy_c = 1'b1;
          if (mc_cycles > MC_ONE) begin
            state_nx = MC_BUSY;
            mcnt_nx  = mc_cycles - MC_ONE;
          end
        end else if (stallreq_id) begin
          stall_c = STALL_ID;
        end
      end
      MC_BUSY: begin
        // ID is already held here, so a load-use request needs no extra action
        stall_c   = STALL_MC;
        mc_busy_c = 1'b1;
        if (mcnt != '0) mcnt_nx = mcnt - MC_ONE;
        if (mcnt <= MC_ONE) state_nx = RUN;
      end
      FLUSH: begin
        flush_c    = 1'b1;
        flush_pc_c = addr_q;
        if (fcnt != 3'd0) fcnt_nx = fcnt - 3'd1;
        if (fcnt <= 3'd1) state_nx = RUN;
      end
      default: state_nx = RUN;
    endcase
  end

  // Reset forces every output low regardless of inputs
  always_comb begin
    stall    = rst ? stall_c    : 6'b0;
    flush    = rst ? flush_c    : 1'b0;
    flush_pc = rst ? flush_pc_c : 32'b0;
    mc_busy  = rst ? mc_busy_c  : 1'b0;
  end

`ifdef PIPE_CTRL_PERF_EN
  // Saturating counters: held cycles and accepted redirects
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if ((stall != 6'b0) && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
      if (br_acc && (flush_cnt != '1)) flush_cnt <= flush_cnt + 1'b1;
    end
  end
`endif

endmodule
